// File: rtl/uart_stream_rr_arbiter.sv
// uart_stream_rr_arbiter: 4-way round-robin stream arbiter with packet-locked grants and a burst limit
module uart_stream_rr_arbiter #(
  parameter int W = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     s_valid,
  input  logic [4*W-1:0] s_data,
  input  logic [3:0]     s_last,
  output logic [3:0]     s_ready,
  output logic           m_valid,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  output logic [1:0]     m_id,
  input  logic           m_ready
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_nx;
  logic [1:0] gnt, last_gnt, pick, k;
  logic [7:0] cnt;
  logic lock, xfer;
  // scan downward so the lowest offset from last_gnt+1 wins
  always_comb begin
    pick = last_gnt;
    k = '0;
    for (int i = 3; i >= 0; i--) begin
      k = last_gnt + 2'(i) + 2'd1;
      pick = s_valid[k] ? k : pick;
    end
  end
  always_comb begin
    lock = state == LOCK;
    m_valid = lock & s_valid[gnt];
    m_data = lock ? s_data[int'(gnt)*W +: W] : '0;
    m_id = gnt;
    s_ready = lock ? (4'(m_ready) << gnt) : 4'b0000;
    m_last = m_valid & (s_last[gnt] | (cnt == 8'(MAX_BURST-1)));
    xfer = m_valid & m_ready;
    state_nx = lock ? ((xfer & m_last) ? ARB : LOCK) : (|s_valid ? LOCK : ARB);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      gnt <= '0;
      last_gnt <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (!lock && |s_valid) begin
        gnt <= pick;
        cnt <= '0;
      end else if (xfer) begin
        cnt <= m_last ? 8'd0 : cnt + 8'd1;
        if (m_last) last_gnt <= gnt;
      end
    end
endmodule
